cfg_ocl_responder: RTL and testbench
====================================

Name: cfg_ocl_responder

Overview:
- AXI-Lite (OCL) slave on tile 0 that lets the host program read the build-time configuration and write the runtime configuration.
- Returns a read-only identity/config ROM: VERSION, tile/thread counts, packed queue sizes.
- Holds the runtime-writable registers (CQ slice size, TQ spill threshold, scratch) and drives them into the CQ and task unit.
- Host software checks VERSION here before touching any other register.

Parameters:
- VERSION, 10, design version word returned at 0x00
- N_TILES, 1, number of tiles, returned at 0x04
- N_THREADS, 32, threads per tile, returned at 0x08
- LOG_CQ_SLICE_SIZE, 7, log2 of the max CQ entries per tile
- LOG_TQ_SIZE, 12, log2 of the task array size
- ADDR_W, 8, AXI-Lite byte-address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_awvalid/s_awready  in/out  1  write-address handshake
- s_awaddr  in  ADDR_W  write byte address
- s_wvalid/s_wready  in/out  1  write-data handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_bvalid  out  1  write-response valid
- s_bready  in  1  write-response ready
- s_bresp  out  2  write response code
- s_arvalid/s_arready  in/out  1  read-address handshake
- s_araddr  in  ADDR_W  read byte address
- s_rvalid  out  1  read-data valid
- s_rready  in  1  read-data ready
- s_rdata  out  32  read data
- s_rresp  out  2  read response code
- cfg_cq_size  out  LOG_CQ_SLICE_SIZE+1  active CQ entries per tile
- cfg_spill_thresh  out  LOG_TQ_SIZE+1  TQ occupancy at which spilling starts

Behaviour:
- Address map, bits [1:0] ignored:
  - 0x00 VERSION, RO
  - 0x04 N_TILES, RO
  - 0x08 N_THREADS, RO
  - 0x0C packed RO: {16'b0, LOG_TQ_SIZE[7:0], LOG_CQ_SLICE_SIZE[7:0]}
  - 0x10 CQ_SIZE, RW
  - 0x14 SPILL_THRESH, RW
  - 0x18 SCRATCH, RW, 32 bits
- Any other address is unmapped.
- Reset values:
  - all ready/valid outputs 0; bresp, rresp, rdata 0
  - CQ_SIZE = 2^LOG_CQ_SLICE_SIZE
  - SPILL_THRESH = 2^LOG_TQ_SIZE - 2^(LOG_TQ_SIZE-2)
  - SCRATCH = 0
  - reset mid-transaction abandons it: no response is issued afterwards.
- Write channel FSM W_IDLE -> W_RESP -> W_IDLE:
  - awready and wready are each 1 in W_IDLE until their own beat is captured, so AW and W are accepted independently, in either order or together.
  - When both beats are held: apply the write, raise bvalid on the same edge and enter W_RESP. awready = wready = 0 in W_RESP.
  - bvalid stays 1 until bready; then back to W_IDLE. Min throughput: one write per 2 cycles.
- Write rules:
  - byte strobes apply to SCRATCH only; CQ_SIZE and SPILL_THRESH update only when wstrb == 4'hF, otherwise bresp = SLVERR with no update
  - CQ_SIZE clamps: 0 -> 1, > 2^LOG_CQ_SLICE_SIZE -> 2^LOG_CQ_SLICE_SIZE
  - SPILL_THRESH clamps: > 2^LOG_TQ_SIZE -> 2^LOG_TQ_SIZE
  - RO address: bresp = SLVERR (2'b10), no effect
  - unmapped address: bresp = DECERR (2'b11)
  - otherwise bresp = OKAY
- Read channel FSM R_IDLE -> R_DATA:
  - arready = 1 in R_IDLE.
  - On AR handshake: register rdata/rresp, rvalid = 1 the next cycle.
  - rdata/rresp hold while rvalid && !rready; return to R_IDLE on rready.
  - Unmapped read: rdata = 0, rresp = DECERR. RW registers read back zero-extended.
- Read and write in the same cycle to the same register: the read returns the pre-write value; the write is visible to the next read.
- cfg_* outputs are driven directly by the registers; a new value appears the cycle after the write applies.

Optional Feature:
- Macro: CFG_WRITE_LOCK_EN.
- With the macro defined:
  - adds LOCK at 0x1C (RW, bit 0; other bits read 0).
  - writing 1 sets the lock sticky; only rst_n clears it.
  - while locked, writes to 0x10/0x14/0x18 return SLVERR and do not update; writes to 0x1C return OKAY and have no effect.
- Without the macro: 0x1C is unmapped (DECERR) and there is no lock logic.

Test Plan:
- After reset, read 0x00 -> rdata = 10, rresp = 0; read 0x0C -> rdata = 0x0000_0C07.
- Write 0x10 = 40 with AW two cycles before W -> bresp = 0 one cycle after the W beat; cfg_cq_size = 40; readback = 40.
- Write 0x10 = 0, then 0x10 = 500 -> cfg_cq_size = 1, then 128. Write 0x14 = 9000 -> cfg_spill_thresh = 4096.
- Write 0x18 = 0xAABBCCDD with wstrb = 4'b0101 from reset -> readback 0x00BB00DD. Write 0x00 -> SLVERR, VERSION unchanged. Read 0x40 -> DECERR, rdata = 0.
- Hold rready = 0 for 5 cycles with rvalid up -> rdata stable, arready = 0. Hold bready = 0 -> no new AW/W accepted. Same-cycle read and write of 0x18 (old 0 -> new 5) -> read returns 0; next read returns 5.
- CFG_WRITE_LOCK_EN: write 0x1C = 1, then 0x10 = 64 -> SLVERR, cfg_cq_size unchanged; pulse rst_n low -> lock cleared, CQ_SIZE = 128.

Source files
------------

// File: rtl/cfg_ocl_responder.sv
// cfg_ocl_responder: AXI-Lite (OCL) slave on tile 0. It serves the read-only
// identity/config words and holds the runtime-writable configuration
// registers that drive the CQ and task unit.
// Optional build macro: CFG_WRITE_LOCK_EN adds a sticky write lock at 0x1C.
module cfg_ocl_responder #(
    parameter int VERSION           = 10,
    parameter int N_TILES           = 1,
    parameter int N_THREADS         = 32,
    parameter int LOG_CQ_SLICE_SIZE = 7,
    parameter int LOG_TQ_SIZE       = 12,
    parameter int ADDR_W            = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_awvalid,
    output logic                       s_awready,
    input  logic [ADDR_W-1:0]          s_awaddr,
    input  logic                       s_wvalid,
    output logic                       s_wready,
    input  logic [31:0]                s_wdata,
    input  logic [3:0]                 s_wstrb,
    output logic                       s_bvalid,
    input  logic                       s_bready,
    output logic [1:0]                 s_bresp,
    input  logic                       s_arvalid,
    output logic                       s_arready,
    input  logic [ADDR_W-1:0]          s_araddr,
    output logic                       s_rvalid,
    input  logic                       s_rready,
    output logic [31:0]                s_rdata,
    output logic [1:0]                 s_rresp,
    output logic [LOG_CQ_SLICE_SIZE:0] cfg_cq_size,
    output logic [LOG_TQ_SIZE:0]       cfg_spill_thresh
);

    localparam int CQ_W = LOG_CQ_SLICE_SIZE + 1;
    localparam int SP_W = LOG_TQ_SIZE + 1;
    localparam int WA_W = ADDR_W - 2;

    localparam logic [CQ_W-1:0] CQ_MAX = {1'b1, {LOG_CQ_SLICE_SIZE{1'b0}}};
    localparam logic [SP_W-1:0] SP_MAX = {1'b1, {LOG_TQ_SIZE{1'b0}}};
    localparam logic [SP_W-1:0] SP_RST = SP_MAX - (SP_MAX >> 2);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [ADDR_W-1:0] A_VERSION = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_TILES   = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_THREADS = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_SIZES   = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_CQ      = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_SPILL   = ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(32'h18);
`ifdef CFG_WRITE_LOCK_EN
    localparam logic [ADDR_W-1:0] A_LOCK    = ADDR_W'(32'h1C);
`endif

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // Zero maps to one entry; anything above the slice capacity saturates.
    function automatic logic [CQ_W-1:0] clamp_cq(input logic [31:0] v);
        if (v == 32'd0)            return CQ_W'(1);
        else if (v > 32'(CQ_MAX))  return CQ_MAX;
        else                       return v[CQ_W-1:0];
    endfunction

    // The spill threshold can never exceed the task array size.
    function automatic logic [SP_W-1:0] clamp_sp(input logic [31:0] v);
        if (v > 32'(SP_MAX)) return SP_MAX;
        else                 return v[SP_W-1:0];
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++)
            m[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return m;
    endfunction

    w_state_e          w_state_q, w_state_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q,  w_held_d;
    logic [WA_W-1:0]   awaddr_q,  awaddr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [3:0]        wstrb_q,   wstrb_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic [CQ_W-1:0]   cq_q,      cq_d;
    logic [SP_W-1:0]   sp_q,      sp_d;
    logic [31:0]       scratch_q, scratch_d;
    r_state_e          r_state_q, r_state_d;
    logic              rvalid_q,  rvalid_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic              rdy_en_q;

`ifdef CFG_WRITE_LOCK_EN
    logic lock_q, lock_d;
    logic locked;
    assign locked = lock_q;
`else
    localparam logic locked = 1'b0;
`endif

    logic              aw_fire, w_fire;
    logic [WA_W-1:0]   eff_word;
    logic [31:0]       eff_data;
    logic [3:0]        eff_strb;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [31:0]       rd_data;
    logic [1:0]        rd_resp;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

    // Readies stay low through reset and the first cycle after it.
    assign s_awready = rdy_en_q && (w_state_q == W_IDLE) && !aw_held_q;
    assign s_wready  = rdy_en_q && (w_state_q == W_IDLE) && !w_held_q;
    assign s_arready = rdy_en_q && (r_state_q == R_IDLE);
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign cfg_cq_size      = cq_q;
    assign cfg_spill_thresh = sp_q;

    assign aw_fire  = s_awvalid && s_awready;
    assign w_fire   = s_wvalid && s_wready;
    assign eff_word = aw_held_q ? awaddr_q : s_awaddr[ADDR_W-1:2];
    assign eff_data = w_held_q ? wdata_q : s_wdata;
    assign eff_strb = w_held_q ? wstrb_q : s_wstrb;
    assign wr_addr  = {eff_word, 2'b00};
    assign rd_addr  = {s_araddr[ADDR_W-1:2], 2'b00};

    // Read decode from current register state (pre-write on a same-cycle write).
    always_comb begin
        rd_data = 32'd0;
        rd_resp = RESP_OKAY;
        case (rd_addr)
            A_VERSION: rd_data = 32'(VERSION);
            A_TILES:   rd_data = 32'(N_TILES);
            A_THREADS: rd_data = 32'(N_THREADS);
            A_SIZES:   rd_data = {16'b0, 8'(LOG_TQ_SIZE), 8'(LOG_CQ_SLICE_SIZE)};
            A_CQ:      rd_data = 32'(cq_q);
            A_SPILL:   rd_data = 32'(sp_q);
            A_SCRATCH: rd_data = scratch_q;
`ifdef CFG_WRITE_LOCK_EN
            A_LOCK:    rd_data = {31'b0, lock_q};
`endif
            default:   rd_resp = RESP_DECERR;
        endcase
    end

    // Write FSM next state: collect AW and W independently, apply once both are in.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        cq_d      = cq_q;
        sp_d      = sp_q;
        scratch_d = scratch_q;
`ifdef CFG_WRITE_LOCK_EN
        lock_d    = lock_q;
`endif
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_awaddr[ADDR_W-1:2];
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                end
                if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    bresp_d   = RESP_OKAY;
                    case (wr_addr)
                        A_VERSION, A_TILES, A_THREADS, A_SIZES:
                            bresp_d = RESP_SLVERR;
                        A_CQ:
                            if (eff_strb != 4'hF || locked) bresp_d = RESP_SLVERR;
                            else                            cq_d = clamp_cq(eff_data);
                        A_SPILL:
                            if (eff_strb != 4'hF || locked) bresp_d = RESP_SLVERR;
                            else                            sp_d = clamp_sp(eff_data);
                        A_SCRATCH:
                            if (locked) bresp_d = RESP_SLVERR;
                            else        scratch_d = merge_bytes(scratch_q, eff_data, eff_strb);
`ifdef CFG_WRITE_LOCK_EN
                        A_LOCK:
                            if (eff_data[0]) lock_d = 1'b1;
`endif
                        default:
                            bresp_d = RESP_DECERR;
                    endcase
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM next state: register the decoded word on AR, hold until R handshake.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_arvalid && s_arready) begin
                    rdata_d   = rd_data;
                    rresp_d   = rd_resp;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State and register update; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q  <= 1'b0;
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            cq_q      <= CQ_MAX;
            sp_q      <= SP_RST;
            scratch_q <= '0;
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
`ifdef CFG_WRITE_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            rdy_en_q  <= 1'b1;
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            cq_q      <= cq_d;
            sp_q      <= sp_d;
            scratch_q <= scratch_d;
            r_state_q <= r_state_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
`ifdef CFG_WRITE_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_cfg_ocl_responder.sv
// Testbench for cfg_ocl_responder: directed register-map checks followed by
// randomized accesses compared against a register-level reference model.
module tb_cfg_ocl_responder;

    localparam int CQ_MAX = 128;
    localparam int SP_MAX = 4096;
    localparam int SP_RST = 3072;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_awvalid = 1'b0, s_awready;
    logic [7:0]  s_awaddr = '0;
    logic        s_wvalid = 1'b0, s_wready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_bvalid, s_bready = 1'b0;
    logic [1:0]  s_bresp;
    logic        s_arvalid = 1'b0, s_arready;
    logic [7:0]  s_araddr = '0;
    logic        s_rvalid, s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [7:0]  cfg_cq_size;
    logic [12:0] cfg_spill_thresh;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_cq, m_sp;
    logic [31:0] m_scr;
    logic        m_lock;

    cfg_ocl_responder dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .cfg_cq_size(cfg_cq_size), .cfg_spill_thresh(cfg_spill_thresh)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cq = CQ_MAX; m_sp = SP_RST; m_scr = 32'd0; m_lock = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] resp);
        int word;
        word = int'(a) / 4;
        resp = 2'b00;
        if (word <= 3) resp = 2'b10;
        else if (word == 4) begin
            if (s != 4'hF || m_lock) resp = 2'b10;
            else m_cq = (d == 0) ? 1 : ((d > CQ_MAX) ? CQ_MAX : int'(d));
        end else if (word == 5) begin
            if (s != 4'hF || m_lock) resp = 2'b10;
            else m_sp = (d > SP_MAX) ? SP_MAX : int'(d);
        end else if (word == 6) begin
            if (m_lock) resp = 2'b10;
            else for (int b = 0; b < 4; b++) if (s[b]) m_scr[b*8 +: 8] = d[b*8 +: 8];
        end
`ifdef CFG_WRITE_LOCK_EN
        else if (word == 7) begin
            if (d[0]) m_lock = 1'b1;
        end
`endif
        else resp = 2'b11;
    endtask

    task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int word;
        word = int'(a) / 4;
        resp = 2'b00;
        case (word)
            0: d = 32'd10;
            1: d = 32'd1;
            2: d = 32'd32;
            3: d = (32'd12 << 8) | 32'd7;
            4: d = 32'(m_cq);
            5: d = 32'(m_sp);
            6: d = m_scr;
`ifdef CFG_WRITE_LOCK_EN
            7: d = {31'b0, m_lock};
`endif
            default: begin d = 32'd0; resp = 2'b11; end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        model_reset();
    endtask

    // Full write transaction. aw_dly/w_dly: cycles before each valid rises.
    // bhold: cycles with bready low, during which a second AW/W is offered.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int bhold,
                             output logic [1:0] resp, output logic lat_ok);
        int cyc;
        bit aw_done, w_done, aw_hs, w_hs;
        cyc = 0; aw_done = 0; w_done = 0;
        resp = 2'bxx; lat_ok = 1'b0;
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        while (!(aw_done && w_done)) begin
            s_awvalid = !aw_done && (cyc >= aw_dly);
            s_wvalid  = !w_done && (cyc >= w_dly);
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(negedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            cyc++;
            if (cyc > 40) begin
                chk("write_handshake_timeout", 32'd1, 32'd0);
                s_awvalid = 0; s_wvalid = 0;
                return;
            end
        end
        s_awvalid = 0; s_wvalid = 0;
        lat_ok = s_bvalid;
        for (int i = 0; i < bhold; i++) begin
            s_awvalid = 1; s_wvalid = 1;
            chk("bhold_awready", {31'b0, s_awready}, 32'd0);
            chk("bhold_wready",  {31'b0, s_wready},  32'd0);
            @(negedge clk);
            chk("bhold_bvalid", {31'b0, s_bvalid}, 32'd1);
        end
        s_awvalid = 0; s_wvalid = 0;
        for (int i = 0; i < 10 && !s_bvalid; i++) @(negedge clk);
        if (!s_bvalid) begin
            chk("bvalid_timeout", 32'd1, 32'd0);
            return;
        end
        resp = s_bresp;
        s_bready = 1;
        @(negedge clk);
        s_bready = 0;
        chk("bvalid_drop", {31'b0, s_bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [7:0] a, input int rhold,
                            output logic [31:0] d, output logic [1:0] resp);
        int cyc;
        cyc = 0;
        d = 32'hxxxx_xxxx; resp = 2'bxx;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1;
        while (!s_arready) begin
            @(negedge clk);
            cyc++;
            if (cyc > 20) begin
                chk("arready_timeout", 32'd1, 32'd0);
                s_arvalid = 0;
                return;
            end
        end
        @(negedge clk);
        s_arvalid = 0;
        if (!s_rvalid) begin
            chk("rvalid_latency", 32'd0, 32'd1);
            return;
        end
        d = s_rdata; resp = s_rresp;
        for (int i = 0; i < rhold; i++) begin
            @(negedge clk);
            chk("rhold_rdata",   s_rdata, d);
            chk("rhold_arready", {31'b0, s_arready}, 32'd0);
        end
        s_rready = 1;
        @(negedge clk);
        s_rready = 0;
        chk("rvalid_drop", {31'b0, s_rvalid}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, ed;
        logic [1:0]  rr, er, br;
        logic        lat;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_awready", {31'b0, s_awready}, 32'd0);
        chk("rst_wready",  {31'b0, s_wready},  32'd0);
        chk("rst_arready", {31'b0, s_arready}, 32'd0);
        chk("rst_bvalid",  {31'b0, s_bvalid},  32'd0);
        chk("rst_rvalid",  {31'b0, s_rvalid},  32'd0);
        chk("rst_bresp",   {30'b0, s_bresp},   32'd0);
        chk("rst_rresp",   {30'b0, s_rresp},   32'd0);
        chk("rst_rdata",   s_rdata,            32'd0);
        chk("rst_cq",      32'(cfg_cq_size),      32'd128);
        chk("rst_spill",   32'(cfg_spill_thresh), 32'd3072);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // ROM reads
        axi_read(8'h00, 0, rd, rr);
        chk("version_data", rd, 32'd10);
        chk("version_resp", {30'b0, rr}, 32'd0);
        axi_read(8'h0C, 0, rd, rr);
        chk("sizes_data", rd, 32'h0000_0C07);
        axi_read(8'h05, 0, rd, rr);
        chk("tiles_lowbits_ignored", rd, 32'd1);
        axi_read(8'h08, 0, rd, rr);
        chk("threads_data", rd, 32'd32);

        // CQ size write, AW two cycles ahead of W
        axi_write(8'h10, 32'd40, 4'hF, 0, 2, 0, br, lat);
        chk("cq40_bresp", {30'b0, br}, 32'd0);
        chk("cq40_bvalid_latency", {31'b0, lat}, 32'd1);
        chk("cq40_cfg", 32'(cfg_cq_size), 32'd40);
        axi_read(8'h10, 0, rd, rr);
        chk("cq40_readback", rd, 32'd40);

        // W ahead of AW
        axi_write(8'h10, 32'd77, 4'hF, 3, 0, 0, br, lat);
        chk("cq77_bvalid_latency", {31'b0, lat}, 32'd1);
        chk("cq77_cfg", 32'(cfg_cq_size), 32'd77);

        // Clamping
        axi_write(8'h10, 32'd0, 4'hF, 0, 0, 0, br, lat);
        chk("cq0_clamp", 32'(cfg_cq_size), 32'd1);
        axi_write(8'h10, 32'd500, 4'hF, 0, 0, 0, br, lat);
        chk("cq500_clamp", 32'(cfg_cq_size), 32'd128);
        axi_write(8'h14, 32'd9000, 4'hF, 0, 0, 0, br, lat);
        chk("spill9000_clamp", 32'(cfg_spill_thresh), 32'd4096);
        chk("spill9000_bresp", {30'b0, br}, 32'd0);
        axi_write(8'h14, 32'd4096, 4'hF, 0, 0, 0, br, lat);
        chk("spill4096_edge", 32'(cfg_spill_thresh), 32'd4096);
        axi_write(8'h14, 32'd100, 4'h7, 0, 0, 0, br, lat);
        chk("spill_partial_bresp", {30'b0, br}, 32'd2);
        chk("spill_partial_noupd", 32'(cfg_spill_thresh), 32'd4096);

        // Byte strobes on SCRATCH (still at its reset value)
        axi_write(8'h18, 32'hAABB_CCDD, 4'b0101, 1, 0, 0, br, lat);
        chk("scratch_strb_bresp", {30'b0, br}, 32'd0);
        axi_read(8'h18, 0, rd, rr);
        chk("scratch_strb_readback", rd, 32'h00BB_00DD);

        // RO write, unmapped read and write
        axi_write(8'h00, 32'h1234_5678, 4'hF, 0, 0, 0, br, lat);
        chk("ro_write_bresp", {30'b0, br}, 32'd2);
        axi_read(8'h00, 0, rd, rr);
        chk("ro_version_kept", rd, 32'd10);
        axi_read(8'h40, 0, rd, rr);
        chk("unmapped_rresp", {30'b0, rr}, 32'd3);
        chk("unmapped_rdata", rd, 32'd0);
        axi_write(8'h40, 32'd1, 4'hF, 0, 0, 0, br, lat);
        chk("unmapped_bresp", {30'b0, br}, 32'd3);
`ifndef CFG_WRITE_LOCK_EN
        axi_read(8'h1C, 0, rd, rr);
        chk("lock_absent_rresp", {30'b0, rr}, 32'd3);
`endif

        // Backpressure on R and B
        axi_read(8'h00, 5, rd, rr);
        chk("rhold_value", rd, 32'd10);
        axi_write(8'h18, 32'd0, 4'hF, 0, 0, 3, br, lat);
        chk("bhold_bresp", {30'b0, br}, 32'd0);

        // Same-cycle read and write of SCRATCH (0 -> 5)
        @(negedge clk);
        s_awaddr = 8'h18; s_wdata = 32'd5; s_wstrb = 4'hF; s_araddr = 8'h18;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        chk("same_cycle_readies", {29'b0, s_awready, s_wready, s_arready}, 32'd7);
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        chk("same_cycle_rvalid", {31'b0, s_rvalid}, 32'd1);
        chk("same_cycle_old_value", s_rdata, 32'd0);
        s_bready = 1; s_rready = 1;
        @(negedge clk);
        s_bready = 0; s_rready = 0;
        axi_read(8'h18, 0, rd, rr);
        chk("same_cycle_new_value", rd, 32'd5);

        // Reset mid-transaction abandons responses
        @(negedge clk);
        s_awaddr = 8'h10; s_wdata = 32'd3; s_wstrb = 4'hF; s_araddr = 8'h00;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        rst_n = 0;
        #1;
        chk("abandon_bvalid_in_reset", {31'b0, s_bvalid}, 32'd0);
        chk("abandon_rvalid_in_reset", {31'b0, s_rvalid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        chk("abandon_no_bvalid", {31'b0, s_bvalid}, 32'd0);
        chk("abandon_no_rvalid", {31'b0, s_rvalid}, 32'd0);
        chk("abandon_cq_reset", 32'(cfg_cq_size), 32'd128);
        model_reset();

`ifdef CFG_WRITE_LOCK_EN
        axi_write(8'h1C, 32'd1, 4'hF, 0, 0, 0, br, lat);
        chk("lock_set_bresp", {30'b0, br}, 32'd0);
        axi_read(8'h1C, 0, rd, rr);
        chk("lock_readback", rd, 32'd1);
        axi_write(8'h10, 32'd64, 4'hF, 0, 0, 0, br, lat);
        chk("locked_cq_bresp", {30'b0, br}, 32'd2);
        chk("locked_cq_kept", 32'(cfg_cq_size), 32'd128);
        axi_write(8'h1C, 32'd0, 4'hF, 0, 0, 0, br, lat);
        chk("locked_lock_write_okay", {30'b0, br}, 32'd0);
        do_reset();
        axi_read(8'h1C, 0, rd, rr);
        chk("lock_cleared", rd, 32'd0);
        axi_write(8'h10, 32'd64, 4'hF, 0, 0, 0, br, lat);
        chk("unlocked_cq_write", 32'(cfg_cq_size), 32'd64);
        do_reset();
`endif

        // Randomized accesses against the reference model
        for (int it = 0; it < 120; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 8) a = 8'(sel * 4 + $urandom_range(0, 3));
            else         a = 8'(8'h20 + $urandom_range(0, 8'hDF));
            case ($urandom_range(0, 3))
                0:       d = 32'($urandom_range(0, 600));
                1:       d = 32'($urandom_range(3000, 9000));
                default: d = $urandom;
            endcase
            s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                model_write(a, d, s, er);
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 0, br, lat);
                chk($sformatf("rand_bresp_%0d_a%02h", it, a), {30'b0, br}, {30'b0, er});
                chk($sformatf("rand_blat_%0d", it), {31'b0, lat}, 32'd1);
                chk($sformatf("rand_cq_%0d", it), 32'(cfg_cq_size), 32'(m_cq));
                chk($sformatf("rand_spill_%0d", it), 32'(cfg_spill_thresh), 32'(m_sp));
            end else begin
                model_read(a, ed, er);
                axi_read(a, $urandom_range(0, 2), rd, rr);
                chk($sformatf("rand_rdata_%0d_a%02h", it, a), rd, ed);
                chk($sformatf("rand_rresp_%0d_a%02h", it, a), {30'b0, rr}, {30'b0, er});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
